// File: rtl/store_align_queue.sv
// Store path: aligns sb/sh/sw/sd onto word lanes with a byte strobe and queues them in order for memory.
// One cycle from accept to mem_valid; req_ready = !full and mem_valid = !empty, both from registered state only.
module store_align_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic            flush,
  output logic            misalign_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [NB-1:0]   mem_wstrb,
  output logic [AW:0]     count
);
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [NB-1:0]   strb;
  } ent_t;

  localparam logic [2:0] MAXF = 3'(OW);

  logic [OW-1:0]   off;
  logic [NB-1:0]   lane;
  logic [XLEN-1:0] dm;
  logic            mis;
  logic            legal;
  logic            acc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  ent_t            din;
  ent_t            head;

  assign off = req_addr[OW-1:0];

  // lane[i] marks the low bytes of the source register covered by the store size
  always_comb begin
    lane = '0;
    dm   = '0;
    mis  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      lane[i]      = (i < (1 << req_funct3[1:0]));
      dm[8*i +: 8] = lane[i] ? req_data[8*i +: 8] : 8'h00;
    end
    for (int j = 0; j < OW; j++) begin
      if (off[j] && (j < int'(req_funct3[1:0]))) mis = 1'b1;
    end
  end

  assign legal     = (req_funct3 <= MAXF) && !mis;
  assign din.addr  = {req_addr[XLEN-1:OW], {OW{1'b0}}};
  assign din.data  = dm << {off, 3'b000};
  assign din.strb  = lane << off;

  assign req_ready = !full;
  assign mem_valid = !empty;
  assign acc       = req_valid && req_ready;
  assign push      = acc && legal;
  assign pop       = mem_valid && mem_ready;

  fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign mem_addr  = head.addr;
  assign mem_wdata = head.data;
  assign mem_wstrb = empty ? '0 : head.strb;

  // a request swallowed by flush never reports an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= acc && !legal && !flush;
  end
endmodule

// Generic in-order FIFO with synchronous flush; storage is cleared on reset so dout is never X.
// Registered one-cycle write-to-read; caller must not push when full nor pop when empty.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign dout  = mem[rd];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: tb/tb_store_align_queue.sv
// Directed bench for store_align_queue (XLEN=64, DEPTH=4) with hand-computed expectations.
module tb_store_align_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic        flush;
  logic        misalign_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_align_queue #(.XLEN(64), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .flush        (flush),
    .misalign_err (misalign_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
    req_valid  = 1'b1;
    req_funct3 = f;
    req_addr   = a;
    req_data   = d;
  endtask

  task automatic head(input string tag, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    chk({tag, "_vld"},  64'(mem_valid), 64'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
    chk({tag, "_strb"}, 64'(mem_wstrb), 64'(s));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_data = '0;
    flush = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mvld",  64'(mem_valid), 64'd0);
    chk("rst_strb",  64'(mem_wstrb), 64'd0);
    chk("rst_err",   64'(misalign_err), 64'd0);
    chk("rst_rdy",   64'(req_ready), 64'd1);
    chk("rst_noX",   64'($isunknown({mem_addr, mem_wdata})), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // sb with immediate drain
    req(3'd0, 64'h1003, 64'hFFFF_FFFF_FFFF_FFAB);
    mem_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("sb_count", 64'(count), 64'd1);
    head("sb", 64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
    step();
    chk("sb_drained", 64'(count), 64'd0);
    chk("sb_empty_strb", 64'(mem_wstrb), 64'd0);

    // sh then sd, held then drained
    mem_ready = 1'b0;
    req(3'd1, 64'h2006, 64'h1234);
    step();
    req(3'd3, 64'h2008, 64'h0123_4567_89AB_CDEF);
    step();
    req_valid = 1'b0;
    chk("shsd_count", 64'(count), 64'd2);
    head("sh", 64'h2000, 64'h1234_0000_0000_0000, 8'hC0);
    step();
    head("sh_hold", 64'h2000, 64'h1234_0000_0000_0000, 8'hC0);
    mem_ready = 1'b1;
    step();
    head("sd", 64'h2008, 64'h0123_4567_89AB_CDEF, 8'hFF);
    chk("sd_count", 64'(count), 64'd1);
    step();
    chk("shsd_drained", 64'(count), 64'd0);

    // illegal stores
    req(3'd2, 64'h2002, 64'hDEAD_BEEF);
    step();
    req_valid = 1'b0;
    chk("mis_sw_err", 64'(misalign_err), 64'd1);
    chk("mis_sw_count", 64'(count), 64'd0);
    chk("mis_sw_mvld", 64'(mem_valid), 64'd0);
    step();
    chk("mis_sw_pulse", 64'(misalign_err), 64'd0);
    req(3'd5, 64'h2000, 64'h1);
    step();
    req_valid = 1'b0;
    chk("f5_err", 64'(misalign_err), 64'd1);
    chk("f5_count", 64'(count), 64'd0);
    step();
    chk("f5_pulse", 64'(misalign_err), 64'd0);
    chk("f5_mvld", 64'(mem_valid), 64'd0);

    // fill to full, then drain in order
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(3'd3, 64'h3000 + 64'(8 * i), 64'hA0 + 64'(i));
      #1;
      chk($sformatf("fill%0d_rdy", i), 64'(req_ready), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    req_valid = 1'b0;
    chk("full_count", 64'(count), 64'd4);
    mem_ready = 1'b1;
    #1;
    chk("full_rdy_not_comb", 64'(req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      head($sformatf("drain%0d", i), 64'h3000 + 64'(8 * i), 64'hA0 + 64'(i), 8'hFF);
      step();
      if (i == 0) chk("rdy_after_pop", 64'(req_ready), 64'd1);
    end
    chk("drain_count", 64'(count), 64'd0);

    // refill past the wrapped pointers, with simultaneous push and pop
    mem_ready = 1'b0;
    req(3'd0, 64'h4001, 64'h55);
    step();
    head("wrap0", 64'h4000, 64'h5500, 8'h02);
    mem_ready = 1'b1;
    req(3'd1, 64'h4002, 64'hBEEF);
    step();
    req_valid = 1'b0;
    chk("pushpop_count", 64'(count), 64'd1);
    head("wrap1", 64'h4000, 64'h0000_0000_BEEF_0000, 8'h0C);
    step();
    chk("wrap_drained", 64'(count), 64'd0);

    // flush beats push and pop
    mem_ready = 1'b0;
    req(3'd3, 64'h5000, 64'h1);
    step();
    req(3'd3, 64'h5008, 64'h2);
    step();
    chk("pre_flush_count", 64'(count), 64'd2);
    req(3'd3, 64'h5010, 64'h3);
    flush = 1'b1;
    mem_ready = 1'b1;
    step();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_mvld", 64'(mem_valid), 64'd0);
    chk("flush_strb", 64'(mem_wstrb), 64'd0);
    req(3'd2, 64'h5001, 64'h4);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_noerr", 64'(misalign_err), 64'd0);
    chk("flush2_count", 64'(count), 64'd0);

    // asynchronous reset with three entries queued
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(3'd0, 64'h6000 + 64'(i), 64'h11 * 64'(i + 1));
      step();
    end
    req_valid = 1'b0;
    chk("prerst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_mvld", 64'(mem_valid), 64'd0);
    chk("arst_noX", 64'($isunknown({mem_addr, mem_wdata})), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_mvld", 64'(mem_valid), 64'd0);
    req(3'd1, 64'h6004, 64'hA5A5);
    step();
    req_valid = 1'b0;
    chk("postrst_count", 64'(count), 64'd1);
    head("postrst", 64'h6000, 64'h0000_A5A5_0000_0000, 8'h30);
    mem_ready = 1'b1;
    step();
    chk("postrst_drained", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
